// File: rtl/alu_ctrl.sv
// alu_ctrl: execute controller sequencing an external 8-bit alu over a 4-entry register file.
// Define ALU_CTRL_ILLEGAL_TRAP_EN to trap opcodes 9-15 (illegal port) instead of retiring them as NOPs.
module alu_ctrl #(
  parameter int NREGS = 4,
  parameter int DW    = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          instr_valid,
  output logic          instr_ready,
  input  logic [11:0]   instr,
  input  logic [DW-1:0] imm,
  output logic [DW-1:0] alu_in0,
  output logic [DW-1:0] alu_in1,
  output logic [3:0]    alu_select,
  output logic [1:0]    alu_num_rotate,
  input  logic [DW-1:0] alu_out,
  output logic          done,
  output logic [DW-1:0] result,
  output logic          zero
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
  ,
  output logic          illegal
`endif
);
  typedef enum logic [1:0] {IDLE, EXEC, DONE, TRAP} state_e;
  state_e        state_q, state_d;
  logic [DW-1:0] rf_q [NREGS];
  logic [DW-1:0] rf_d [NREGS];
  logic [3:0]    op_q, op_d, sel_q, sel_d;
  logic [1:0]    rd_q, rd_d, nr_q, nr_d;
  logic [DW-1:0] imm_q, imm_d, in0_q, in0_d, in1_q, in1_d, result_q, result_d, wv;
  logic          zero_q, zero_d, accept;
  assign instr_ready    = (state_q == IDLE) || (state_q == DONE);
  assign done           = state_q == DONE;
  assign alu_in0        = in0_q;
  assign alu_in1        = in1_q;
  assign alu_select     = sel_q;
  assign alu_num_rotate = nr_q;
  assign result         = result_q;
  assign zero           = zero_q;
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
  assign illegal        = state_q == TRAP;
`endif
  always_comb begin
    accept   = instr_valid && instr_ready;
    wv       = (op_q == 4'd8) ? imm_q : alu_out;
    state_d  = state_q;
    rf_d     = rf_q;
    op_d     = op_q;
    rd_d     = rd_q;
    imm_d    = imm_q;
    in0_d    = in0_q;
    in1_d    = in1_q;
    sel_d    = sel_q;
    nr_d     = nr_q;
    result_d = result_q;
    zero_d   = zero_q;
    if (state_q == EXEC) begin
      state_d = DONE;
      if (op_q <= 4'd8) begin
        rf_d[rd_q] = wv;
        result_d   = wv;
        zero_d     = wv == '0;
      end
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
    // Only real alu opcodes (0-7) touch the alu ports; LDI and 9-15 leave them alone.
    if (accept) begin
      op_d  = instr[11:8];
      rd_d  = instr[7:6];
      imm_d = imm;
      if (!instr[11]) begin
        in0_d = rf_q[instr[5:4]];
        in1_d = rf_q[instr[3:2]];
        sel_d = instr[11:8];
        nr_d  = instr[1:0];
      end
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
      state_d = (instr[11] && instr[10:8] != 3'd0) ? TRAP : EXEC;
`else
      state_d = EXEC;
`endif
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rf_q     <= '{default: '0};
      op_q     <= '0;
      rd_q     <= '0;
      imm_q    <= '0;
      in0_q    <= '0;
      in1_q    <= '0;
      sel_q    <= '0;
      nr_q     <= '0;
      result_q <= '0;
      zero_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      rf_q     <= rf_d;
      op_q     <= op_d;
      rd_q     <= rd_d;
      imm_q    <= imm_d;
      in0_q    <= in0_d;
      in1_q    <= in1_d;
      sel_q    <= sel_d;
      nr_q     <= nr_d;
      result_q <= result_d;
      zero_q   <= zero_d;
    end
  end
endmodule

// File: tb/tb_alu_ctrl.sv
// tb_alu_ctrl: directed plus randomized checks of alu_ctrl against an instruction-level register-file model.
// Works in both builds; ALU_CTRL_ILLEGAL_TRAP_EN selects the trap expectations.
module tb_alu_ctrl;
  logic        clk = 0, rst_n = 0, instr_valid = 0;
  logic        instr_ready, done, zero;
  logic [11:0] instr = '0;
  logic [7:0]  imm = '0, alu_in0, alu_in1, alu_out, result;
  logic [3:0]  alu_select;
  logic [1:0]  alu_num_rotate;
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
  logic        illegal;
`endif
  int checks = 0, failures = 0, cyc = 0, last_done = 0;
  logic [7:0] rf [4];
  logic [7:0] m_res, p_in0, p_in1;
  logic [3:0] p_sel;
  logic [1:0] p_nr;
  logic       m_zero;

  alu_ctrl dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .imm(imm), .alu_in0(alu_in0), .alu_in1(alu_in1),
    .alu_select(alu_select), .alu_num_rotate(alu_num_rotate), .alu_out(alu_out),
    .done(done), .result(result), .zero(zero)
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
    , .illegal(illegal)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Stand-in for the external combinational alu.
  always_comb begin
    alu_out = '0;
    case (alu_select)
      4'd0: alu_out = alu_in0;
      4'd1: alu_out = alu_in0 & alu_in1;
      4'd2: alu_out = (alu_in0 << alu_num_rotate) | (alu_in0 >> (4'd8 - {2'b0, alu_num_rotate}));
      4'd3: alu_out = (alu_in0 >> alu_num_rotate) | (alu_in0 << (4'd8 - {2'b0, alu_num_rotate}));
      4'd4: alu_out = alu_in0 + alu_in1;
      4'd5: alu_out = alu_in0 - alu_in1;
      4'd6: alu_out = alu_in0 + 8'd1;
      4'd7: alu_out = alu_in0 - 8'd1;
      default: alu_out = '0;
    endcase
  end

  function automatic logic [7:0] ref_alu(input int op, input int a, input int b, input int nr);
    int r;
    case (op)
      0: r = a;
      1: r = a & b;
      2: r = (a << nr) | (a >> (8 - nr));
      3: r = (a >> nr) | (a << (8 - nr));
      4: r = a + b;
      5: r = a - b;
      6: r = a + 1;
      7: r = a - 1;
      default: r = 0;
    endcase
    return 8'(r);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) rf[i] = '0;
    m_res = '0; m_zero = 1'b1;
    p_in0 = '0; p_in1 = '0; p_sel = '0; p_nr = '0;
  endtask

  task automatic do_reset();
    instr_valid = 0;
    rst_n = 0;
    @(posedge clk);
    #1 rst_n = 1;
    model_reset();
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      chk("idle_done", done, 0);
      chk("idle_ready", instr_ready, 1);
    end
  endtask

  task automatic send(input logic [3:0] op, input logic [1:0] rd, input logic [1:0] rs,
                      input logic [1:0] rt, input logic [1:0] nr, input logic [7:0] im);
    logic [7:0] a, b, v;
    int n, acc;
    instr_valid = 1; instr = {op, rd, rs, rt, nr}; imm = im;
    n = 0;
    while (!instr_ready && n < 20) begin @(negedge clk); n++; end
    chk("accept_timeout", n < 20, 1);
    @(posedge clk);
    #1 acc = cyc;
    instr_valid = 0; instr = 12'($urandom); imm = 8'($urandom);
    a = rf[rs]; b = rf[rt];
    if (op < 8) begin p_in0 = a; p_in1 = b; p_sel = op; p_nr = nr; end
    @(negedge clk);
    chk("exec_ready", instr_ready, 0);
    chk("exec_done", done, 0);
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
    if (op > 8) begin
      chk("trap_illegal", illegal, 1);
      return;
    end
    chk("no_illegal", illegal, 0);
`endif
    if (op <= 8) begin
      chk("alu_in0", alu_in0, p_in0);
      chk("alu_in1", alu_in1, p_in1);
      chk("alu_select", alu_select, p_sel);
      chk("alu_num_rotate", alu_num_rotate, p_nr);
    end
    v = (op < 8) ? ref_alu(op, a, b, nr) : im;
    if (op <= 8) begin rf[rd] = v; m_res = v; m_zero = v == 0; end
    @(negedge clk);
    chk("done_pulse", done, 1);
    chk("done_ready", instr_ready, 1);
    chk("done_latency", cyc, acc + 1);
    chk("result", result, m_res);
    chk("zero", zero, m_zero);
    last_done = cyc;
  endtask

  initial begin
    int prev;
    logic [7:0] held;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    @(negedge clk);
    chk("rst_ready", instr_ready, 1);
    chk("rst_done", done, 0);
    chk("rst_result", result, 0);
    chk("rst_zero", zero, 1);
    chk("rst_in0", alu_in0, 0);
    chk("rst_sel", alu_select, 0);
    idle(2);
    send(4'd8, 2'd0, 2'd0, 2'd0, 2'd0, 8'd2);
    send(4'd8, 2'd1, 2'd0, 2'd0, 2'd0, 8'd1);
    send(4'd4, 2'd2, 2'd0, 2'd1, 2'd0, 8'd0);
    chk("add_const", result, 8'd3);
    chk("add_zero", zero, 0);
    idle(1);
    send(4'd8, 2'd0, 2'd0, 2'd0, 2'd0, 8'h81);
    send(4'd2, 2'd3, 2'd0, 2'd0, 2'd2, 8'd0);
    chk("rotl_const", result, 8'h06);
    send(4'd3, 2'd3, 2'd0, 2'd0, 2'd2, 8'd0);
    chk("rotr_const", result, 8'h60);
    send(4'd8, 2'd0, 2'd0, 2'd0, 2'd0, 8'd1);
    send(4'd8, 2'd1, 2'd0, 2'd0, 2'd0, 8'd2);
    send(4'd5, 2'd2, 2'd0, 2'd1, 2'd0, 8'd0);
    chk("sub_wrap", result, 8'hFF);
    send(4'd8, 2'd3, 2'd0, 2'd0, 2'd0, 8'hFF);
    send(4'd6, 2'd3, 2'd3, 2'd0, 2'd0, 8'd0);
    chk("inc_wrap", result, 8'h00);
    chk("inc_zero", zero, 1);
    send(4'd7, 2'd3, 2'd3, 2'd0, 2'd0, 8'd0);
    chk("dec_wrap", result, 8'hFF);
    idle(1);
    send(4'd8, 2'd0, 2'd0, 2'd0, 2'd0, 8'hF0);
    prev = last_done;
    send(4'd8, 2'd1, 2'd0, 2'd0, 2'd0, 8'h3C);
    chk("b2b_spacing", last_done - prev, 2);
    prev = last_done;
    send(4'd1, 2'd2, 2'd0, 2'd1, 2'd0, 8'd0);
    chk("b2b_spacing", last_done - prev, 2);
    chk("and_const", result, 8'h30);
    prev = last_done;
    send(4'd4, 2'd3, 2'd2, 2'd2, 2'd0, 8'd0);
    chk("b2b_spacing", last_done - prev, 2);
    chk("dependent_const", result, 8'h60);
    idle(1);
    // Reset landing in the EXEC cycle must abort the add.
    instr_valid = 1; instr = {4'd4, 2'd2, 2'd0, 2'd1, 2'd0};
    @(posedge clk);
    #1 instr_valid = 0;
    do_reset();
    @(negedge clk);
    chk("abort_done", done, 0);
    chk("abort_result", result, 0);
    chk("abort_zero", zero, 1);
    chk("abort_ready", instr_ready, 1);
    send(4'd0, 2'd3, 2'd2, 2'd0, 2'd0, 8'd0);
    chk("abort_readback", result, 8'd0);
    for (int k = 0; k < 40; k++) begin
      send(4'($urandom_range(0, 8)), 2'($urandom), 2'($urandom), 2'($urandom), 2'($urandom), 8'($urandom));
      if ($urandom_range(0, 2) != 0) idle($urandom_range(1, 2));
    end
    idle(1);
    held = m_res;
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
    send(4'd12, 2'd1, 2'd0, 2'd0, 2'd0, 8'd0);
    instr_valid = 1; instr = {4'd8, 2'd0, 2'd0, 2'd0, 2'd0};
    repeat (4) begin
      @(negedge clk);
      chk("trap_hold", illegal, 1);
      chk("trap_ready", instr_ready, 0);
      chk("trap_done", done, 0);
    end
    do_reset();
    @(negedge clk);
    chk("trap_cleared", illegal, 0);
    chk("trap_rst_ready", instr_ready, 1);
`else
    send(4'd12, 2'd1, 2'd0, 2'd0, 2'd0, 8'd0);
    chk("nop_result", result, held);
    send(4'd0, 2'd2, 2'd1, 2'd0, 2'd0, 8'd0);
    chk("nop_no_write", result, rf[1]);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
